// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF       = 32;
   localparam int DATA_W_DEF       = 32;
   localparam int MAX_D_STREAK_DEF = 4;
   localparam int STREAK_W         = 4;

   // Transaction sequencing states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_RD = 2'd2
   } state_e;

   // Which requester owns the outstanding transaction.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   // Saturating increment of the data-grant streak.
   function automatic logic [STREAK_W-1:0] streak_inc(
      input logic [STREAK_W-1:0] cur,
      input logic [STREAK_W-1:0] max_v
   );
      return (cur >= max_v) ? max_v : cur + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data requesters, with a streak counter
// that forces a fetch grant after too many consecutive data grants.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic arb_en,
   input  logic if_req,
   input  logic d_req,
   output logic if_win,
   output logic d_win
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   logic [STREAK_W-1:0] streak_q;

   // Data has priority unless fetch has waited through a full streak.
   always_comb begin
      if_win = arb_en && if_req && (!d_req || (streak_q == STREAK_MAX));
      d_win  = arb_en && d_req && !if_win;
   end

   // Count data grants that bypassed a waiting fetch; any other grant clears.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         streak_q <= '0;
      end else if (d_win) begin
         streak_q <= if_req ? streak_inc(streak_q, STREAK_MAX) : '0;
      end else if (if_win) begin
         streak_q <= '0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one
// transaction outstanding at a time, with request/grant/response handshakes.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   state_e              state_q, state_d;
   owner_e              owner_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                arb_en;
   logic                if_win;
   logic                d_win;

   // Grants are only issued from IDLE, and never while reset is applied,
   // so a requester is never told it was accepted into a discarded slot.
   assign arb_en = (state_q == IDLE) && !rst_i;

   mem_arb_prio #(
      .MAX_D_STREAK (MAX_D_STREAK)
   ) u_prio (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .arb_en (arb_en),
      .if_req (if_req_i),
      .d_req  (d_req_i),
      .if_win (if_win),
      .d_win  (d_win)
   );

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the winning request so the memory side sees stable values.
   // NOTE: the datapath latch is reset as well, because mem_addr_o and
   // mem_wdata_o are driven straight from it and must read 0 after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (if_win) begin
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= if_addr_i;
         wdata_q <= '0;
      end else if (d_win) begin
         owner_q <= OWN_D;
         we_q    <= d_we_i;
         addr_q  <= d_addr_i;
         wdata_q <= d_wdata_i;
      end
   end

   // Next-state and handshake outputs.
   // NOTE: every signal written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      mem_req_o   = 1'b0;
      if_rvalid_o = 1'b0;
      d_rvalid_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (if_win || d_win) begin
               state_d = REQ;
            end
         end
         REQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
               if (we_q) begin
                  // A store completes on acceptance; there is no read data.
                  d_rvalid_o = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (mem_rvalid_i) begin
               if (owner_q == OWN_D) begin
                  d_rvalid_o = 1'b1;
               end else begin
                  if_rvalid_o = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Reset silences the handshake immediately, so a memory response
      // racing with reset never reaches a requester.
      if (rst_i) begin
         mem_req_o   = 1'b0;
         if_rvalid_o = 1'b0;
         d_rvalid_o  = 1'b0;
      end
   end

   assign if_gnt_o    = if_win;
   assign d_gnt_o     = d_win;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   // Read data is a pure mirror; rvalid is the only qualifier.
   assign if_rdata_o  = mem_rdata_i;
   assign d_rdata_o   = mem_rdata_i;

   // Grants are mutually exclusive and only come out of IDLE.
   a_gnt_excl : assert property (@(posedge clk_i) !(if_gnt_o && d_gnt_o));
   a_gnt_idle : assert property (@(posedge clk_i)
                                 (if_gnt_o || d_gnt_o) |-> (state_q == IDLE));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the data (load/store) requester of the core.
- Sequences each access through a request/grant/response handshake, with one transaction outstanding at a time.
- Data requests have priority; a streak counter prevents fetch starvation.
- Sits between the core's imem/dmem ports and the unified memory model or SRAM wrapper.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_D_STREAK, 4, max consecutive data grants while fetch is pending before fetch is forced (range 1..15).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse).
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse).
- if_rdata_o  out  DATA_W  fetch data.
- d_req_i  in  1  data request; held until d_gnt_o.
- d_we_i  in  1  1=store, 0=load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_gnt_o  out  1  data request accepted (1-cycle pulse).
- d_rvalid_o  out  1  data transaction complete; load data valid.
- d_rdata_o  out  DATA_W  load data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory read data valid.
- mem_rdata_i  in  DATA_W  memory read data.

Behaviour:
- FSM states:
  - IDLE: no transaction.
  - REQ: mem_req_o high, waiting for mem_gnt_i.
  - WAIT_RD: granted read, waiting for mem_rvalid_i.
- IDLE arbitration, combinational in cycle N:
  - Fetch wins if if_req_i && (!d_req_i || streak==MAX_D_STREAK).
  - Otherwise data wins if d_req_i.
  - The winner's gnt_o pulses in cycle N.
  - Owner, we, addr and wdata are latched at the N edge; state becomes REQ in N+1.
- Grants occur only in IDLE. if_gnt_o and d_gnt_o are never high in the same cycle.
- REQ:
  - mem_req_o=1; mem_we/addr/wdata come from latched registers and stay stable until mem_gnt_i.
  - On mem_gnt_i with a read: go to WAIT_RD.
  - On mem_gnt_i with a write: go to IDLE and pulse d_rvalid_o in the same cycle as mem_gnt_i.
- WAIT_RD:
  - On mem_rvalid_i, pulse the owner's rvalid_o in the same cycle; rdata_o = mem_rdata_i (combinational); go to IDLE.
  - The non-owner's rvalid_o stays 0.
- Minimum latency, zero-wait memory (gnt and rvalid in the first possible cycle):
  - Read: gnt at N, mem_req N+1, rvalid to requester N+2. Back-to-back reads: one every 3 cycles.
  - Write: complete at N+1, next grant at N+2.
- if_rdata_o and d_rdata_o both mirror mem_rdata_i; they are qualified only by rvalid.
- mem_rvalid_i outside WAIT_RD is ignored and causes no state change.
- mem_gnt_i outside REQ is ignored.
- Streak counter (4 bit):
  - On a data grant with if_req_i also high: increment, saturating at MAX_D_STREAK.
  - On a fetch grant, or a data grant with if_req_i low: clear to 0.
- Requests that drop before grant are legal and simply lose their slot; no grant is issued for them.
- Reset (any cycle, including mid-transaction):
  - Next cycle: state=IDLE, streak=0, owner=fetch, latched regs=0.
  - All outputs 0 (mem_req_o, gnt, rvalid, mem_we_o, mem_addr_o, mem_wdata_o).
  - An in-flight memory response after reset is ignored per the rule above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State enum (IDLE=2'd0, REQ=2'd1, WAIT_RD=2'd2).
  - Owner encoding (OWN_IF=1'b0, OWN_D=1'b1).
  - Default widths.
- One natural sub-module: mem_arb_prio, the combinational winner select plus streak counter. The FSM and datapath latch stay in mem_arbiter.

Test Plan:
- Fetch read, zero-wait memory, if_addr=0x100, mem_rdata=0xDEADBEEF -> if_gnt N, mem_req N+1 with addr 0x100, if_rvalid N+2 with data 0xDEADBEEF; d_rvalid_o stays 0.
- Simultaneous if_req and d_req store (addr 0x2000, wdata 0x55) -> d_gnt first, mem_we=1 with addr 0x2000, d_rvalid at mem_gnt; then if_gnt in the next IDLE cycle.
- if_req held high, d_req continuously high, MAX_D_STREAK=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Memory holds mem_gnt low 3 cycles during a load -> mem_req/addr stable all 4 cycles; a new d_req/if_req is not granted until the transaction completes.
- Spurious mem_rvalid_i in IDLE and REQ -> no rvalid_o pulse, no state change.
- rst_i asserted in WAIT_RD, mem_rvalid arrives the cycle after -> all outputs 0 after reset, no rvalid_o; a fresh fetch then completes normally.
